branch_unit: RTL and testbench

Parametrised, registered branch resolution unit for the RISC-V core's execute stage. Compares two WIDTH-bit operands under all six RV32I branch conditions selected by funct3, computes the branch target, checks the outcome against the front-end prediction and registers the result one cycle later for the fetch redirect path. Maintains wrap-around branch and mispredict counters for the CSR/performance logic.

---
 rtl/branch_unit.sv | 153 +++++++++++++++
 tb/tb_branch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Registered branch resolution: compares rs1/rs2 under the RV32I branch conditions,
// picks the redirect PC, flags mispredicts and keeps wrap-around performance counters.
module branch_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2:0]           funct3,
    input  logic [WIDTH-1:0]     rs1,
    input  logic [WIDTH-1:0]     rs2,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     imm,
    input  logic                 pred_taken,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 cnt_clear,
    output logic                 out_valid,
    output logic                 taken,
    output logic                 mispredict,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 breq,
    output logic                 brlt,
    output logic                 brltu,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic eval_cond(input logic [2:0] f, input logic eq,
                                       input logic lt, input logic ltu);
        logic c;
        c = 1'b0;
        case (f)
            F3_BEQ:  c = eq;
            F3_BNE:  c = !eq;
            F3_BLT:  c = lt;
            F3_BGE:  c = !lt;
            F3_BLTU: c = ltu;
            F3_BGEU: c = !ltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic is_illegal(input logic [2:0] f);
        return (f == 3'b010) || (f == 3'b011);
    endfunction

    // Stage p0: combinational compare, condition and target selection
    logic signed [WIDTH-1:0] rs1_s_p0;
    logic signed [WIDTH-1:0] rs2_s_p0;
    logic                    breq_p0;
    logic                    brlt_p0;
    logic                    brltu_p0;
    logic                    cond_p0;
    logic                    illegal_p0;
    logic                    mispred_p0;
    logic [WIDTH-1:0]        target_p0;
    logic [WIDTH-1:0]        fallthru_p0;
    logic [WIDTH-1:0]        redirect_p0;
    logic                    count_p0;

    assign rs1_s_p0    = rs1;
    assign rs2_s_p0    = rs2;
    assign breq_p0     = (rs1 == rs2);
    assign brltu_p0    = (rs1 < rs2);
    assign brlt_p0     = (rs1_s_p0 < rs2_s_p0);
    assign illegal_p0  = is_illegal(funct3);
    assign cond_p0     = eval_cond(funct3, breq_p0, brlt_p0, brltu_p0);
    assign mispred_p0  = (cond_p0 ^ pred_taken) & ~illegal_p0;
    assign target_p0   = pc + imm;
    assign fallthru_p0 = pc + WIDTH'(4);
    assign redirect_p0 = cond_p0 ? target_p0 : fallthru_p0;
    assign count_p0    = in_valid && !flush && !illegal_p0;

    // Stage p1: result and counter registers
    logic                 vld_p1;
    logic                 taken_p1;
    logic                 mispred_p1;
    logic [WIDTH-1:0]     redirect_p1;
    logic                 breq_p1;
    logic                 brlt_p1;
    logic                 brltu_p1;
    logic                 illegal_p1;
    logic [CNT_WIDTH-1:0] branch_cnt_p1;
    logic [CNT_WIDTH-1:0] mispred_cnt_p1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1         <= 1'b0;
            taken_p1       <= 1'b0;
            mispred_p1     <= 1'b0;
            redirect_p1    <= '0;
            breq_p1        <= 1'b0;
            brlt_p1        <= 1'b0;
            brltu_p1       <= 1'b0;
            illegal_p1     <= 1'b0;
            branch_cnt_p1  <= '0;
            mispred_cnt_p1 <= '0;
        end else if (!stall) begin
            if (flush || !in_valid) begin
                vld_p1      <= 1'b0;
                taken_p1    <= 1'b0;
                mispred_p1  <= 1'b0;
                redirect_p1 <= '0;
                breq_p1     <= 1'b0;
                brlt_p1     <= 1'b0;
                brltu_p1    <= 1'b0;
                illegal_p1  <= 1'b0;
            end else begin
                vld_p1      <= 1'b1;
                taken_p1    <= cond_p0;
                mispred_p1  <= mispred_p0;
                redirect_p1 <= redirect_p0;
                breq_p1     <= breq_p0;
                brlt_p1     <= brlt_p0;
                brltu_p1    <= brltu_p0;
                illegal_p1  <= illegal_p0;
            end
            // Clearing takes precedence over a same-cycle increment.
            if (cnt_clear) begin
                branch_cnt_p1  <= '0;
                mispred_cnt_p1 <= '0;
            end else if (count_p0) begin
                branch_cnt_p1 <= branch_cnt_p1 + CNT_WIDTH'(1);
                if (mispred_p0) begin
                    mispred_cnt_p1 <= mispred_cnt_p1 + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign out_valid   = vld_p1;
    assign taken       = taken_p1;
    assign mispredict  = mispred_p1;
    assign redirect_pc = redirect_p1;
    assign breq        = breq_p1;
    assign brlt        = brlt_p1;
    assign brltu       = brltu_p1;
    assign illegal     = illegal_p1;
    assign branch_cnt  = branch_cnt_p1;
    assign mispred_cnt = mispred_cnt_p1;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed scenarios plus randomized traffic, all checked
// against an arithmetic reference model of the branch rules.
module tb_branch_unit;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [2:0]    funct3;
    logic [W-1:0]  rs1, rs2, pc, imm;
    logic          pred_taken, stall, flush, cnt_clear;
    logic          out_valid, taken, mispredict, breq, brlt, brltu, illegal;
    logic [W-1:0]  redirect_pc;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .stall(stall), .flush(flush), .cnt_clear(cnt_clear),
        .out_valid(out_valid), .taken(taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .breq(breq), .brlt(brlt), .brltu(brltu),
        .illegal(illegal), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (expected register contents)
    logic    m_valid, m_taken, m_misp, m_eq, m_lt, m_ltu, m_ill;
    longint  m_pc;
    int      m_bcnt, m_mcnt;

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        longint a, b, sa, sb, modw, tgt, ft;
        logic c, ill, eq, lt, ltu, mis;
        if (!rst) begin
            {m_valid, m_taken, m_misp, m_eq, m_lt, m_ltu, m_ill} = '0;
            m_pc = 0; m_bcnt = 0; m_mcnt = 0;
            return;
        end
        if (stall) return;
        modw = longint'(1) << W;
        a  = longint'(rs1);
        b  = longint'(rs2);
        sa = rs1[W-1] ? a - modw : a;
        sb = rs2[W-1] ? b - modw : b;
        eq = (a == b); lt = (sa < sb); ltu = (a < b);
        ill = 1'b0;
        case (funct3)
            3'd0: c = eq;
            3'd1: c = !eq;
            3'd4: c = lt;
            3'd5: c = !lt;
            3'd6: c = ltu;
            3'd7: c = !ltu;
            default: begin c = 1'b0; ill = 1'b1; end
        endcase
        mis = ill ? 1'b0 : (c != pred_taken);
        tgt = (longint'(pc) + longint'(imm)) % modw;
        ft  = (longint'(pc) + 4) % modw;
        if (flush || !in_valid) begin
            {m_valid, m_taken, m_misp, m_eq, m_lt, m_ltu, m_ill} = '0;
            m_pc = 0;
        end else begin
            m_valid = 1; m_taken = c; m_misp = mis;
            m_eq = eq; m_lt = lt; m_ltu = ltu; m_ill = ill;
            m_pc = c ? tgt : ft;
        end
        if (cnt_clear) begin
            m_bcnt = 0; m_mcnt = 0;
        end else if (in_valid && !flush && !ill) begin
            m_bcnt = (m_bcnt + 1) % (1 << CW);
            if (mis) m_mcnt = (m_mcnt + 1) % (1 << CW);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"},   out_valid,   m_valid);
        chk({tag, ".taken"},       taken,       m_taken);
        chk({tag, ".mispredict"},  mispredict,  m_misp);
        chk({tag, ".redirect_pc"}, redirect_pc, m_pc);
        chk({tag, ".breq"},        breq,        m_eq);
        chk({tag, ".brlt"},        brlt,        m_lt);
        chk({tag, ".brltu"},       brltu,       m_ltu);
        chk({tag, ".illegal"},     illegal,     m_ill);
        chk({tag, ".branch_cnt"},  branch_cnt,  m_bcnt);
        chk({tag, ".mispred_cnt"}, mispred_cnt, m_mcnt);
    endtask

    // Apply current inputs across one rising edge, then check 1 time unit later
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] p,
                         input logic [W-1:0] i, input logic pt);
        in_valid = v; funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt;
        stall = 0; flush = 0; cnt_clear = 0;
    endtask

    task automatic drive_rand();
        logic [W-1:0] a;
        a = $urandom;
        drive(1'b1, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
              $urandom, $urandom, 1'($urandom));
    endtask

    initial begin
        rst = 0;
        drive(1'b1, 3'd0, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0);
        tick("reset0");
        tick("reset1");
        chk("reset.valid_lit", out_valid, 0);
        rst = 1;
        tick("rel_load");
        chk("rel_load.valid_lit", out_valid, 1);

        // Signed versus unsigned compare
        drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h2000, 32'h40, 1'b1);
        tick("blt");
        chk("blt.taken_lit", {taken, brlt, brltu}, 3'b110);
        funct3 = 3'b110; tick("bltu");
        chk("bltu.taken_lit", taken, 0);
        funct3 = 3'b111; tick("bgeu");
        chk("bgeu.taken_lit", taken, 1);

        // Target and redirect, with counters cleared first
        drive(1'b0, 3'd0, 0, 0, 0, 0, 0); cnt_clear = 1; tick("clr");
        drive(1'b1, 3'b000, 32'd5, 32'd5, 32'h1000, 32'hFFFF_FFF0, 1'b0);
        tick("beq_tgt");
        chk("beq_tgt.pc_lit", redirect_pc, 32'h0000_0FF0);
        chk("beq_tgt.mcnt_lit", mispred_cnt, 1);
        rs2 = 32'd6; tick("beq_ft");
        chk("beq_ft.pc_lit", redirect_pc, 32'h0000_1004);

        // Stall holds everything, then flush kills the next instruction
        drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h3000, 32'h8, 1'b0);
        tick("bne");
        for (int k = 0; k < 3; k++) begin
            drive_rand(); stall = 1; flush = k[0]; cnt_clear = 1;
            tick("stall");
        end
        drive_rand(); flush = 1; tick("flush");

        // Illegal funct3
        drive(1'b1, 3'b010, 32'd3, 32'd3, 32'h4000, 32'h10, 1'b1);
        tick("ill010");
        funct3 = 3'b011; pred_taken = 0; tick("ill011");

        // 16 mispredicted branches wrap both 4-bit counters
        drive(1'b0, 3'd0, 0, 0, 0, 0, 0); cnt_clear = 1; tick("clr2");
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 3'b000, 32'd9, 32'd9, 32'(k * 4), 32'h100, 1'b0);
            tick("wrap");
        end
        chk("wrap.cnt_lit", {branch_cnt, mispred_cnt}, 8'h00);
        drive(1'b1, 3'b000, 32'd9, 32'd9, 32'h0, 32'h100, 1'b0); tick("pre_clr");
        cnt_clear = 1; tick("clr_valid");
        chk("clr_valid.lit", {out_valid, branch_cnt, mispred_cnt}, 9'h100);

        // Reset mid-stream, then restart
        drive_rand(); tick("pre_rst");
        rst = 0; drive_rand(); tick("mid_rst");
        rst = 1; drive_rand(); tick("post_rst");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive_rand();
            in_valid  = ($urandom_range(0, 7) != 0);
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            cnt_clear = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) != 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
